// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC conversion sequencer: FSM state encoding and
// SAR averaging control codes.
package adc_seq_pkg;

    localparam int AVG_CODE_W = 3;

    localparam logic [AVG_CODE_W-1:0] AVG_NONE = 3'b000;
    localparam logic [AVG_CODE_W-1:0] AVG_2X   = 3'b001;
    localparam logic [AVG_CODE_W-1:0] AVG_4X   = 3'b010;
    localparam logic [AVG_CODE_W-1:0] AVG_8X   = 3'b011;
    localparam logic [AVG_CODE_W-1:0] AVG_16X  = 3'b100;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SELECT  = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_CONVERT = 3'd3;
    localparam logic [2:0] ST_STORE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        SELECT  = ST_SELECT,
        SETTLE  = ST_SETTLE,
        CONVERT = ST_CONVERT,
        STORE   = ST_STORE
    } seq_state_e;

endpackage

// File: rtl/adc_seq_chan_picker.sv
// Combinational find-first-set: lowest enabled channel whose index is at or
// above the scan pointer.
module adc_seq_chan_picker
    import adc_seq_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int CH_BITS      = 2
) (
    input  logic [NUM_CHANNELS-1:0] mask_in,
    input  logic [CH_BITS:0]        ptr_in,
    output logic [CH_BITS-1:0]      index_out,
    output logic                    found_out
);

    // Scan downwards so the lowest qualifying channel is the last one written.
    always_comb begin
        index_out = '0;
        found_out = 1'b0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (mask_in[i] && ((CH_BITS + 1)'(i) >= ptr_in)) begin
                index_out = CH_BITS'(i);
                found_out = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_conversion_sequencer.sv
// Multi-channel scan scheduler around the nonbinary SAR controller.
// Optional conversion watchdog enabled by defining ADC_SEQ_TIMEOUT_EN.
module adc_conversion_sequencer
    import adc_seq_pkg::*;
#(
    parameter int NUM_CHANNELS   = 4,
    parameter int CH_BITS        = 2,
    parameter int RESULT_BITS    = 12,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_in,
    input  logic                           continuous_in,
    input  logic [NUM_CHANNELS-1:0]        channel_mask_in,
    input  logic [AVG_CODE_W*NUM_CHANNELS-1:0] avg_cfg_in,
    input  logic                           clear_flags_in,
    input  logic                           conv_finished_in,
    input  logic [RESULT_BITS-1:0]         adc_result_in,
    output logic                           adc_rst_n_out,
    output logic [AVG_CODE_W-1:0]          avg_control_out,
    output logic [CH_BITS-1:0]             channel_sel_out,
    output logic [RESULT_BITS-1:0]         data_out,
    output logic [CH_BITS-1:0]             data_channel_out,
    output logic                           data_valid_out,
    input  logic                           data_ready_in,
    output logic                           busy_out,
    output logic                           overrun_out,
    output logic                           timeout_err_out
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    seq_state_e               state_q, state_d;
    logic [CH_BITS:0]         ptr_q, ptr_d;
    logic [CH_BITS-1:0]       chan_q, chan_d;
    logic [AVG_CODE_W-1:0]    avg_q, avg_d;
    logic [SETTLE_W-1:0]      settle_q, settle_d;
    logic [RESULT_BITS-1:0]   result_q, result_d;
    logic [RESULT_BITS-1:0]   data_q, data_d;
    logic [CH_BITS-1:0]       data_ch_q, data_ch_d;
    logic                     valid_q, valid_d;
    logic                     overrun_q, overrun_d;
    logic [CH_BITS-1:0]       pick_idx;
    logic                     pick_found;

`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic                     timeout_q, timeout_d;
`endif

    adc_seq_chan_picker #(
        .NUM_CHANNELS(NUM_CHANNELS),
        .CH_BITS     (CH_BITS)
    ) u_picker (
        .mask_in  (channel_mask_in),
        .ptr_in   (ptr_q),
        .index_out(pick_idx),
        .found_out(pick_found)
    );

    // Sticky flags clear first so a same-cycle set wins.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        chan_d    = chan_q;
        avg_d     = avg_q;
        settle_d  = settle_q;
        result_d  = result_q;
        data_d    = data_q;
        data_ch_d = data_ch_q;
        valid_d   = valid_q && !data_ready_in;
        overrun_d = overrun_q && !clear_flags_in;
`ifdef ADC_SEQ_TIMEOUT_EN
        tmo_d     = tmo_q;
        timeout_d = timeout_q && !clear_flags_in;
`endif
        case (state_q)
            IDLE: begin
                if ((start_in || continuous_in) && (|channel_mask_in)) begin
                    state_d = SELECT;
                    ptr_d   = '0;
                end
            end
            SELECT: begin
                if (pick_found) begin
                    chan_d   = pick_idx;
                    avg_d    = avg_cfg_in[int'(pick_idx)*AVG_CODE_W +: AVG_CODE_W];
                    settle_d = '0;
                    state_d  = SETTLE;
                end else begin
                    ptr_d   = '0;
                    state_d = continuous_in ? SELECT : IDLE;
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    state_d = CONVERT;
`ifdef ADC_SEQ_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            CONVERT: begin
                if (conv_finished_in) begin
                    result_d = adc_result_in;
                    state_d  = STORE;
                end
`ifdef ADC_SEQ_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    ptr_d     = {1'b0, chan_q} + (CH_BITS + 1)'(1);
                    state_d   = SELECT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            STORE: begin
                data_d    = result_q;
                data_ch_d = chan_q;
                valid_d   = 1'b1;
                if (valid_q && !data_ready_in) begin
                    overrun_d = 1'b1;
                end
                ptr_d   = {1'b0, chan_q} + (CH_BITS + 1)'(1);
                state_d = SELECT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            chan_q    <= '0;
            avg_q     <= '0;
            settle_q  <= '0;
            result_q  <= '0;
            data_q    <= '0;
            data_ch_q <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
            tmo_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            chan_q    <= chan_d;
            avg_q     <= avg_d;
            settle_q  <= settle_d;
            result_q  <= result_d;
            data_q    <= data_d;
            data_ch_q <= data_ch_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
`ifdef ADC_SEQ_TIMEOUT_EN
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // The SAR controller only runs while converting; every other state holds it in reset.
    assign adc_rst_n_out    = (state_q == CONVERT);
    assign busy_out         = (state_q != IDLE);
    assign avg_control_out  = avg_q;
    assign channel_sel_out  = chan_q;
    assign data_out         = data_q;
    assign data_channel_out = data_ch_q;
    assign data_valid_out   = valid_q;
    assign overrun_out      = overrun_q;
`ifdef ADC_SEQ_TIMEOUT_EN
    assign timeout_err_out  = timeout_q;
`else
    assign timeout_err_out  = 1'b0;
`endif

endmodule
